demux_1x8_seq: RTL and testbench

Sequential 1-to-8 demultiplexer/deserializer, the receiving end of the 8x1 mux path.
- Accepts one serial bit per qualified clock and steers it into slot select_line of an internal 8-bit shadow register.
- select_line auto-increments from 0 to 7.
- After slot 7 is filled, the assembled word is published on y with a one-cycle valid pulse.
- Used to rebuild the parallel byte that the 8x1 mux drives out while its select line sweeps 000..111.

---
 rtl/demux_1x8_seq.sv | 86 ++++++++
 tb/tb_demux_1x8_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x8_seq.sv
// demux_1x8_seq: serial-to-parallel 1x8 demux, one qualified bit per clock.
// Optional DEMUX_MSB_FIRST_EN: first accepted bit lands in y[7] instead of y[0].
module demux_1x8_seq #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             a_valid,
  input  logic             clear,
  output logic [SEL_W-1:0] select_line,
  output logic [N-1:0]     y,
  output logic             y_valid,
  output logic             busy
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     y_q, y_d;
  logic             yv_q, yv_d;

  logic [SEL_W-1:0] slot;
  logic [N-1:0]     filled;
  logic             last;

  // Map the running bit index to its slot in the word
  always_comb begin
`ifdef DEMUX_MSB_FIRST_EN
    slot = SEL_W'(N - 1) - sel_q;
`else
    slot = sel_q;
`endif
  end

  // Shadow word as it looks with the current bit dropped in
  always_comb begin
    filled       = shadow_q;
    filled[slot] = a;
    last         = (sel_q == SEL_W'(N - 1));
  end

  // Next state: clear beats accept; the last bit publishes the word
  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    yv_d     = 1'b0;
    if (clear) begin
      sel_d    = '0;
      shadow_d = '0;
    end else if (a_valid) begin
      sel_d    = sel_q + SEL_W'(1);
      shadow_d = filled;
      if (last) begin
        y_d      = filled;
        yv_d     = 1'b1;
        shadow_d = '0;
      end
    end
  end

  // State registers; reset drops any partial frame at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      yv_q     <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      yv_q     <= yv_d;
    end
  end

  // Outputs straight from state; busy marks a partly filled frame
  always_comb begin
    select_line = sel_q;
    y           = y_q;
    y_valid     = yv_q;
    busy        = (sel_q != '0);
  end

endmodule

// File: tb/tb_demux_1x8_seq.sv
// tb_demux_1x8_seq: directed plan plus random traffic against a
// bit-list reference model of the 1x8 deserializer.
module tb_demux_1x8_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a = 1'b0;
  logic       a_valid = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] select_line;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;

  int vectors = 0;
  int errors = 0;

  // reference model: list of bits received in the current frame
  int         m_cnt;
  bit         m_bits[8];
  logic [7:0] m_y;
  logic       m_yv;

  demux_1x8_seq dut (
    .clk(clk), .rst_n(rst_n), .a(a), .a_valid(a_valid),
    .clear(clear), .select_line(select_line), .y(y),
    .y_valid(y_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pack_word();
    logic [7:0] w = 8'h00;
    for (int k = 0; k < 8; k++) begin
`ifdef DEMUX_MSB_FIRST_EN
      w[7-k] = m_bits[k];
`else
      w[k] = m_bits[k];
`endif
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sel"}, {5'd0, select_line}, 8'(m_cnt));
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, m_cnt != 0});
    chk({tag, ".y"}, y, m_y);
    chk({tag, ".yv"}, {7'd0, y_valid}, {7'd0, m_yv});
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_y = 8'h00;
    m_yv = 1'b0;
    for (int k = 0; k < 8; k++) m_bits[k] = 1'b0;
  endtask

  task automatic step(input string tag, input bit b,
                      input bit v, input bit c);
    @(negedge clk);
    a = b;
    a_valid = v;
    clear = c;
    @(posedge clk);
    #1;
    m_yv = 1'b0;
    if (c) begin
      m_cnt = 0;
    end else if (v) begin
      m_bits[m_cnt] = b;
      m_cnt++;
      if (m_cnt == 8) begin
        m_y = pack_word();
        m_yv = 1'b1;
        m_cnt = 0;
      end
    end
    check_all(tag);
  endtask

  task automatic frame(input string tag, input logic [7:0] bits);
    for (int k = 0; k < 8; k++) step(tag, bits[k], 1'b1, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    a_valid = 1'b0;
    clear = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] y_before;

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0);

    // 0,1,0,1,... -> 8'b10101010 (LSB-first)
    frame("aa", 8'b1010_1010);
    chk("aa.word", y,
`ifdef DEMUX_MSB_FIRST_EN
        8'b0101_0101);
`else
        8'b1010_1010);
`endif
    step("aa.post", 1'b0, 1'b0, 1'b0);

    // same stream with a three-cycle gap after bit 4
    for (int k = 0; k < 4; k++) step("gap.a", k[0], 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step("gap.hold", 1'b1, 1'b0, 1'b0);
    for (int k = 4; k < 8; k++) step("gap.b", k[0], 1'b1, 1'b0);

    // five bits, clear, then all ones
    y_before = m_y;
    for (int k = 0; k < 5; k++) step("clr.part", 1'b0, 1'b1, 1'b0);
    step("clr.pulse", 1'b1, 1'b1, 1'b1);
    chk("clr.yheld", y, y_before);
    frame("ones", 8'hFF);
    chk("ones.word", y, 8'hFF);

    // clear on the eighth bit suppresses completion
    for (int k = 0; k < 7; k++) step("clr7.fill", 1'b1, 1'b1, 1'b0);
    step("clr7.abort", 1'b0, 1'b1, 1'b1);

    // asynchronous reset at select_line 3
    for (int k = 0; k < 3; k++) step("ar.fill", 1'b1, 1'b1, 1'b0);
    async_reset("ar");
    frame("ar.after", 8'h5C);

    // back-to-back frames: AA then zeros
    frame("b2b.aa", 8'hAA);
    frame("b2b.zero", 8'h00);
    chk("b2b.word", y, 8'h00);

    // single leading one
    frame("lead1", 8'b0000_0001);
    chk("lead1.word", y,
`ifdef DEMUX_MSB_FIRST_EN
        8'b1000_0000);
`else
        8'b0000_0001);
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 29) == 0));
      if (i == 200) async_reset("rnd.ar");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
